// File: rtl/quad_decoder_filt_if.sv
// Encoder-side bus of quad_decoder_filt: raw phases and control strobes in,
// position count, snapshot and error status out. err_cnt exists only with QDEC_ERR_CNT_EN.
interface quad_decoder_filt_if #(
    parameter int BITS = 24
);
    logic            phase_a;
    logic            phase_b;
    logic            zero;
    logic            snap;
    logic            err_clr;
    logic [BITS-1:0] cnt;
    logic [BITS-1:0] snap_cnt;
    logic            snap_valid;
    logic            dir;
    logic            err;
`ifdef QDEC_ERR_CNT_EN
    logic [7:0]      err_cnt;
`endif

    modport master (
        output phase_a, phase_b, zero, snap, err_clr,
`ifdef QDEC_ERR_CNT_EN
        input  err_cnt,
`endif
        input  cnt, snap_cnt, snap_valid, dir, err
    );

    modport slave (
        input  phase_a, phase_b, zero, snap, err_clr,
`ifdef QDEC_ERR_CNT_EN
        output err_cnt,
`endif
        output cnt, snap_cnt, snap_valid, dir, err
    );
endinterface

// File: rtl/quad_decoder_filt.sv
// Glitch-filtered x4 quadrature decoder with wrap-around count and snapshot.
// Define QDEC_ERR_CNT_EN to add the 8-bit saturating illegal-transition counter.
module quad_decoder_filt #(
    parameter int BITS    = 24,
    parameter int FILT    = 4,
    parameter bit DIR_INV = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    quad_decoder_filt_if.slave bus
);
    localparam logic [7:0] FILT_M1   = 8'(FILT - 1);
    localparam logic [8:0] INIT_LAST = 9'(FILT + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            load;
    logic            run_en;
    logic [8:0]      init_cnt;
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic            filt_a;
    logic            filt_b;
    logic            prev_a;
    logic            prev_b;
    logic [7:0]      run_a;
    logic [7:0]      run_b;
    logic            step;
    logic            illegal;
    logic            up;
    logic [BITS-1:0] cnt;
    logic [BITS-1:0] snap_cnt;
    logic            snap_valid;
    logic            dir;
    logic            err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: if (init_cnt == INIT_LAST) state_nxt = RUN;
            RUN:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        run_en = 1'b0;
        unique case (state)
            INIT: load   = (init_cnt == INIT_LAST);
            RUN:  run_en = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_cnt <= '0;
        else if (state == INIT && !load) init_cnt <= init_cnt + 9'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[0], bus.phase_a};
            sync_b <= {sync_b[0], bus.phase_b};
        end
    end

    // Leaving INIT seeds filter and history from the synchronizer so the
    // resting encoder position never looks like a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_a <= 1'b0;
            filt_b <= 1'b0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
            run_a  <= '0;
            run_b  <= '0;
        end else if (load) begin
            filt_a <= sync_a[1];
            filt_b <= sync_b[1];
            prev_a <= sync_a[1];
            prev_b <= sync_b[1];
            run_a  <= '0;
            run_b  <= '0;
        end else if (run_en) begin
            prev_a <= filt_a;
            prev_b <= filt_b;
            if (sync_a[1] == filt_a) begin
                run_a <= '0;
            end else if (run_a == FILT_M1) begin
                filt_a <= sync_a[1];
                run_a  <= '0;
            end else begin
                run_a <= run_a + 8'd1;
            end
            if (sync_b[1] == filt_b) begin
                run_b <= '0;
            end else if (run_b == FILT_M1) begin
                filt_b <= sync_b[1];
                run_b  <= '0;
            end else begin
                run_b <= run_b + 8'd1;
            end
        end
    end

    // Single-bit change with B_prev != A_now is the A-leads-B direction.
    always_comb begin
        illegal = run_en & (prev_a ^ filt_a) & (prev_b ^ filt_b);
        step    = run_en & ((prev_a ^ filt_a) ^ (prev_b ^ filt_b));
        up      = (prev_b ^ filt_a) ^ DIR_INV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            snap_cnt   <= '0;
            snap_valid <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
        end else begin
            snap_valid <= run_en & bus.snap;
            if (run_en) begin
                if (bus.zero)  cnt <= '0;
                else if (step) cnt <= up ? cnt + BITS'(1) : cnt - BITS'(1);
                if (step)      dir <= up;
                if (bus.snap)  snap_cnt <= cnt;
                if (illegal)   err <= 1'b1;
                else if (bus.err_clr) err <= 1'b0;
            end
        end
    end

`ifdef QDEC_ERR_CNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (run_en) begin
            if (illegal) begin
                if (bus.err_clr)        err_cnt <= 8'd1;
                else if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
            end else if (bus.err_clr) begin
                err_cnt <= '0;
            end
        end
    end

    assign bus.err_cnt = err_cnt;
`endif

    assign bus.cnt        = cnt;
    assign bus.snap_cnt   = snap_cnt;
    assign bus.snap_valid = snap_valid;
    assign bus.dir        = dir;
    assign bus.err        = err;
endmodule

// File: tb/tb_quad_decoder_filt.sv
// Directed bench for quad_decoder_filt: reset, stepping, wrap, glitch,
// illegal transition, and coincident zero/snap/step corner cases.
module tb_quad_decoder_filt;
    localparam int BITS = 24;
    localparam int FILT = 4;
    localparam int HOLD = 8;

    typedef struct {
        logic            a;
        logic            b;
        int              hold;
        logic [BITS-1:0] cnt;
        logic            dir;
        logic            err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   sv_count = 0;
    logic [1:0]      ab;
    logic [BITS-1:0] model_cnt;
    vec_t tbl[4];

    always #5 clk = ~clk;

    quad_decoder_filt_if #(.BITS(BITS)) bus ();

    quad_decoder_filt #(
        .BITS(BITS),
        .FILT(FILT),
        .DIR_INV(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always @(negedge clk) if (rst_n && bus.snap_valid) sv_count++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic drive_ab(input logic [1:0] v);
        ab = v;
        bus.phase_a = v[1];
        bus.phase_b = v[0];
    endtask

    task automatic step(input bit fwd, input string name);
        drive_ab(fwd ? fwd_next(ab) : rev_next(ab));
        wait_n(HOLD);
        model_cnt = fwd ? model_cnt + 1'b1 : model_cnt - 1'b1;
        chk(name, 32'(bus.cnt), 32'(model_cnt));
    endtask

    initial begin
        int sv0;
        logic changed;
        bus.zero = 1'b0;
        bus.snap = 1'b0;
        bus.err_clr = 1'b0;
        drive_ab(2'b11);
        model_cnt = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        wait_n(3);
        chk("rst_cnt", 32'(bus.cnt), 32'd0);
        chk("rst_snap_cnt", 32'(bus.snap_cnt), 32'd0);
        chk("rst_snap_valid", 32'(bus.snap_valid), 32'd0);
        chk("rst_dir", 32'(bus.dir), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        wait_n(100);
        chk("init_cnt", 32'(bus.cnt), 32'd0);
        chk("init_err", 32'(bus.err), 32'd0);
        chk("init_no_snap", 32'(sv_count), 32'd0);

        for (int i = 0; i < 40; i++) step(1'b1, "fwd_cnt");
        chk("fwd40_cnt", 32'(bus.cnt), 32'd40);
        chk("fwd40_dir", 32'(bus.dir), 32'd1);
        for (int i = 0; i < 40; i++) step(1'b0, "rev_cnt");
        chk("rev40_cnt", 32'(bus.cnt), 32'd0);
        chk("rev40_dir", 32'(bus.dir), 32'd0);

        tbl[0] = '{a: 1'b1, b: 1'b0, hold: HOLD, cnt: 24'hFFFFFF, dir: 1'b0, err: 1'b0};
        tbl[1] = '{a: 1'b1, b: 1'b1, hold: HOLD, cnt: 24'h000000, dir: 1'b1, err: 1'b0};
        tbl[2] = '{a: 1'b1, b: 1'b0, hold: HOLD, cnt: 24'hFFFFFF, dir: 1'b0, err: 1'b0};
        tbl[3] = '{a: 1'b0, b: 1'b0, hold: HOLD, cnt: 24'hFFFFFE, dir: 1'b0, err: 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive_ab({tbl[i].a, tbl[i].b});
            wait_n(tbl[i].hold);
            chk($sformatf("tbl%0d_cnt", i), 32'(bus.cnt), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_dir", i), 32'(bus.dir), 32'(tbl[i].dir));
            chk($sformatf("tbl%0d_err", i), 32'(bus.err), 32'(tbl[i].err));
        end

        bus.zero = 1'b1;
        tick();
        bus.zero = 1'b0;
        chk("zero_cnt", 32'(bus.cnt), 32'd0);
        chk("zero_dir", 32'(bus.dir), 32'd0);

        bus.phase_a = 1'b1;
        wait_n(3);
        bus.phase_a = 1'b0;
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.cnt !== '0 || bus.err !== 1'b0) changed = 1'b1;
        end
        chk("glitch_quiet", 32'(changed), 32'd0);

        drive_ab(2'b11);
        wait_n(HOLD);
        chk("ill_cnt", 32'(bus.cnt), 32'd0);
        chk("ill_err", 32'(bus.err), 32'd1);
        chk("ill_dir", 32'(bus.dir), 32'd0);
`ifdef QDEC_ERR_CNT_EN
        chk("ill_err_cnt", 32'(bus.err_cnt), 32'd1);
`endif
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("clr_err", 32'(bus.err), 32'd0);
`ifdef QDEC_ERR_CNT_EN
        chk("clr_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif

        drive_ab(2'b00);
        wait_n(FILT + 2);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("setwins_err", 32'(bus.err), 32'd1);
`ifdef QDEC_ERR_CNT_EN
        chk("setwins_err_cnt", 32'(bus.err_cnt), 32'd1);
`endif
        wait_n(2);
        chk("setwins_cnt", 32'(bus.cnt), 32'd0);

        model_cnt = '0;
        for (int i = 0; i < 40; i++) step(1'b1, "fwd2_cnt");
        chk("pre_snap_cnt", 32'(bus.cnt), 32'd40);
        sv0 = sv_count;
        drive_ab(fwd_next(ab));
        wait_n(FILT + 2);
        bus.zero = 1'b1;
        bus.snap = 1'b1;
        tick();
        bus.zero = 1'b0;
        bus.snap = 1'b0;
        chk("coinc_cnt", 32'(bus.cnt), 32'd0);
        chk("coinc_snap_cnt", 32'(bus.snap_cnt), 32'd40);
        chk("coinc_snap_valid", 32'(bus.snap_valid), 32'd1);
        chk("coinc_dir", 32'(bus.dir), 32'd1);
        tick();
        chk("coinc_snap_drop", 32'(bus.snap_valid), 32'd0);
        wait_n(5);
        chk("coinc_pulses", 32'(sv_count - sv0), 32'd1);
        chk("coinc_cnt_hold", 32'(bus.cnt), 32'd0);

        drive_ab(fwd_next(ab));
        wait_n(HOLD);
        chk("post_cnt", 32'(bus.cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cnt", 32'(bus.cnt), 32'd0);
        chk("async_snap_cnt", 32'(bus.snap_cnt), 32'd0);
        chk("async_dir", 32'(bus.dir), 32'd0);
        chk("async_err", 32'(bus.err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
